// File: rtl/reaction_pkg.sv
// reaction_pkg: shared state encoding and default timing constants for the reaction-timer round sequencer
package reaction_pkg;
  typedef enum logic [2:0] {IDLE, ARM, GO, DONE, FOUL} state_t;
  localparam int DEFAULT_TICK_DIV = 50000;
  localparam int DEFAULT_MIN_DELAY = 1000;
  localparam int DEFAULT_TIMEOUT = 9999;
endpackage

// File: rtl/reaction_round_ctrl_tick_gen.sv
// tick_gen: 1 ms prescaler; tick pulses on the TICK_DIV-th cycle after clear
// ports: clk, reset (async, active-high), clear (restart the period), tick (one-cycle pulse)
module tick_gen import reaction_pkg::*; #(
  parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);
  localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  logic [CW-1:0] cnt;
  assign tick = cnt == CW'(TICK_DIV - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else cnt <= (clear || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/reaction_round_ctrl.sv
// reaction_round_ctrl: reaction-timer round sequencer (random hold-off, reaction count, false start, timeout, best time)
// ports: clk, reset (async, active-high); start/press one-cycle pulses; lfsr_value sampled on start;
//        lfsr_en, lamp, time_ms, result_valid, timeout, false_start, best_ms, best_valid
module reaction_round_ctrl import reaction_pkg::*; #(
  parameter int TICK_DIV  = DEFAULT_TICK_DIV,
  parameter int LFSR_W    = 8,
  parameter int TIME_W    = 14,
  parameter int MIN_DELAY = DEFAULT_MIN_DELAY,
  parameter int TIMEOUT   = DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              press,
  input  logic [LFSR_W-1:0] lfsr_value,
  output logic              lfsr_en,
  output logic              lamp,
  output logic [TIME_W-1:0] time_ms,
  output logic              result_valid,
  output logic              timeout,
  output logic              false_start,
  output logic [TIME_W-1:0] best_ms,
  output logic              best_valid
);
  state_t state, next_state;
  // cnt holds the remaining hold-off in ARM, the reaction count in GO and the result in DONE
  logic [TIME_W-1:0] cnt;
  logic tick, clear;
  logic [TIME_W-1:0] arm_delay;
  assign arm_delay = TIME_W'(MIN_DELAY) + (TIME_W'(lfsr_value) << 2);
  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk(clk),
    .reset(reset),
    .clear(clear),
    .tick(tick)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= next_state;
  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE, FOUL: next_state = start ? ARM : state;
      ARM: next_state = press ? FOUL : (tick && cnt == TIME_W'(1)) ? GO : ARM;
      GO: next_state = (press || (tick && cnt == TIME_W'(TIMEOUT - 1))) ? DONE : GO;
      default: next_state = IDLE;
    endcase
    clear = next_state != state && (next_state == ARM || next_state == GO);
    lfsr_en = state == IDLE;
    lamp = state == GO;
    time_ms = (state == GO || state == DONE) ? cnt : '0;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt <= '0;
      result_valid <= 1'b0;
      timeout <= 1'b0;
      false_start <= 1'b0;
      best_ms <= '0;
      best_valid <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        IDLE, DONE, FOUL:
          if (start) begin
            cnt <= arm_delay;
            timeout <= 1'b0;
            false_start <= 1'b0;
          end
        ARM:
          if (press) false_start <= 1'b1;
          else if (tick) cnt <= cnt - 1'b1;
        GO:
          if (press) begin
            result_valid <= 1'b1;
            if (!best_valid || cnt < best_ms) begin
              best_ms <= cnt;
              best_valid <= 1'b1;
            end
          end else if (tick) begin
            // the final increment lands exactly on TIMEOUT, which becomes the held result
            cnt <= cnt + 1'b1;
            if (cnt == TIME_W'(TIMEOUT - 1)) begin
              timeout <= 1'b1;
              result_valid <= 1'b1;
            end
          end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_reaction_round_ctrl.sv
// tb_reaction_round_ctrl: table-driven rounds with a result scoreboard plus reset/start corner sequences
module tb_reaction_round_ctrl;
  localparam int TD = 4, LW = 4, TW = 8, MIND = 3, TMO = 20;
  logic clk = 1'b0;
  logic reset, start, press;
  logic [LW-1:0] lfsr_value;
  logic lfsr_en, lamp, result_valid, timeout, false_start, best_valid;
  logic [TW-1:0] time_ms, best_ms;
  reaction_round_ctrl #(
    .TICK_DIV(TD), .LFSR_W(LW), .TIME_W(TW), .MIN_DELAY(MIND), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .press(press), .lfsr_value(lfsr_value),
    .lfsr_en(lfsr_en), .lamp(lamp), .time_ms(time_ms), .result_valid(result_valid),
    .timeout(timeout), .false_start(false_start), .best_ms(best_ms), .best_valid(best_valid)
  );
  always #5 clk = ~clk;
  typedef struct {
    int lfsr;
    int foul_at;
    int press_at;
    bit start_in_go;
    int exp_time;
    bit exp_to;
    int exp_best;
  } vec_t;
  typedef struct {
    int t;
    bit to;
    int best;
    bit bv;
  } exp_t;
  exp_t sb[$];
  exp_t e_mon;
  vec_t tbl[7];
  int checks = 0, errors = 0;
  int n;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk)
    if (!reset && result_valid) begin
      if (sb.size() == 0) chk("unexpected result_valid", 1, 0);
      else begin
        e_mon = sb.pop_front();
        chk("sb time_ms", int'(time_ms), e_mon.t);
        chk("sb timeout", int'(timeout), int'(e_mon.to));
        chk("sb best_ms", int'(best_ms), e_mon.best);
        chk("sb best_valid", int'(best_valid), int'(e_mon.bv));
      end
    end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    tbl[0] = '{2, -1, 20, 1'b0, 5, 1'b0, 5};
    tbl[1] = '{2, 3, -1, 1'b0, 0, 1'b0, 5};
    tbl[2] = '{0, -1, 28, 1'b1, 7, 1'b0, 5};
    tbl[3] = '{1, -1, 12, 1'b0, 3, 1'b0, 3};
    tbl[4] = '{3, -1, 27, 1'b0, 6, 1'b0, 3};
    tbl[5] = '{0, -1, -1, 1'b0, 20, 1'b1, 3};
    tbl[6] = '{0, 11, -1, 1'b0, 0, 1'b0, 3};
    reset = 1'b1;
    start = 1'b0;
    press = 1'b0;
    lfsr_value = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset lfsr_en", int'(lfsr_en), 1);
    chk("reset lamp", int'(lamp), 0);
    chk("reset time_ms", int'(time_ms), 0);
    chk("reset result_valid", int'(result_valid), 0);
    chk("reset timeout", int'(timeout), 0);
    chk("reset false_start", int'(false_start), 0);
    chk("reset best_ms", int'(best_ms), 0);
    chk("reset best_valid", int'(best_valid), 0);
    reset = 1'b0;
    press = 1'b1;
    step;
    press = 1'b0;
    chk("idle press ignored lfsr_en", int'(lfsr_en), 1);
    chk("idle press ignored false_start", int'(false_start), 0);
    for (int i = 0; i < 7; i++) begin
      lfsr_value = LW'(tbl[i].lfsr);
      start = 1'b1;
      step;
      start = 1'b0;
      lfsr_value = LW'($urandom);
      chk($sformatf("row%0d arm lamp", i), int'(lamp), 0);
      chk($sformatf("row%0d arm lfsr_en", i), int'(lfsr_en), 0);
      chk($sformatf("row%0d arm timeout cleared", i), int'(timeout), 0);
      chk($sformatf("row%0d arm false_start cleared", i), int'(false_start), 0);
      if (tbl[i].foul_at >= 0) begin
        repeat (tbl[i].foul_at) step;
        press = 1'b1;
        step;
        press = 1'b0;
        chk($sformatf("row%0d foul false_start", i), int'(false_start), 1);
        chk($sformatf("row%0d foul lamp", i), int'(lamp), 0);
        chk($sformatf("row%0d foul time_ms", i), int'(time_ms), 0);
        press = 1'b1;
        step;
        press = 1'b0;
        repeat (2) step;
        chk($sformatf("row%0d foul held", i), int'(false_start), 1);
        chk($sformatf("row%0d foul lamp held", i), int'(lamp), 0);
        chk($sformatf("row%0d foul best_ms", i), int'(best_ms), tbl[i].exp_best);
      end else begin
        n = 0;
        while (!lamp && n < 2000) begin
          step;
          n++;
        end
        chk($sformatf("row%0d lamp latency", i), n, (MIND + 4 * tbl[i].lfsr) * TD);
        chk($sformatf("row%0d go time_ms", i), int'(time_ms), 0);
        if (tbl[i].press_at >= 0) begin
          for (int k = 0; k < tbl[i].press_at; k++) begin
            start = tbl[i].start_in_go && k == 2;
            step;
          end
          start = 1'b0;
          press = 1'b1;
          sb.push_back(exp_t'{tbl[i].exp_time, 1'b0, tbl[i].exp_best, 1'b1});
          step;
          press = 1'b0;
          chk($sformatf("row%0d done lamp", i), int'(lamp), 0);
          chk($sformatf("row%0d done time_ms", i), int'(time_ms), tbl[i].exp_time);
          chk($sformatf("row%0d done result_valid", i), int'(result_valid), 1);
          chk($sformatf("row%0d done best_ms", i), int'(best_ms), tbl[i].exp_best);
        end else begin
          sb.push_back(exp_t'{tbl[i].exp_time, 1'b1, tbl[i].exp_best, 1'b1});
          n = 0;
          while (!result_valid && n < 500) begin
            step;
            n++;
          end
          chk($sformatf("row%0d timeout latency", i), n, TMO * TD);
          chk($sformatf("row%0d timeout flag", i), int'(timeout), int'(tbl[i].exp_to));
          chk($sformatf("row%0d timeout time_ms", i), int'(time_ms), tbl[i].exp_time);
          chk($sformatf("row%0d timeout lamp", i), int'(lamp), 0);
        end
        step;
        chk($sformatf("row%0d single pulse", i), int'(result_valid), 0);
        chk($sformatf("row%0d time_ms held", i), int'(time_ms), tbl[i].exp_time);
      end
    end
    lfsr_value = '0;
    start = 1'b1;
    step;
    start = 1'b0;
    n = 0;
    while (!lamp && n < 2000) begin
      step;
      n++;
    end
    chk("rst round lamp latency", n, MIND * TD);
    repeat (5) step;
    chk("rst precondition best_valid", int'(best_valid), 1);
    reset = 1'b1;
    #1;
    chk("rst lamp", int'(lamp), 0);
    chk("rst lfsr_en", int'(lfsr_en), 1);
    chk("rst best_valid", int'(best_valid), 0);
    chk("rst best_ms", int'(best_ms), 0);
    chk("rst time_ms", int'(time_ms), 0);
    step;
    reset = 1'b0;
    repeat (3) step;
    chk("rst stays idle", int'(lfsr_en), 1);
    start = 1'b1;
    step;
    start = 1'b0;
    n = 0;
    while (!lamp && n < 2000) begin
      step;
      n++;
    end
    repeat (36) step;
    press = 1'b1;
    sb.push_back(exp_t'{9, 1'b0, 9, 1'b1});
    step;
    press = 1'b0;
    chk("post-reset best_ms", int'(best_ms), 9);
    step;
    chk("scoreboard drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/reaction_round_ctrl.md
# reaction_round_ctrl

Round sequencer for the reaction-timer datapath. It free-runs the LFSR while idle and converts a sampled LFSR value into a random millisecond hold-off. It then lights the lamp and measures the player's reaction time in milliseconds, detects false starts and timeouts, and keeps a best-time register. It sits between the debounced button/edge-detect logic and the LFSR and display blocks.

## Interface
Parameters:
- TICK_DIV, 50000: clock cycles per 1 ms tick.
- LFSR_W, 8: width of the sampled LFSR value.
- TIME_W, 14: width of all millisecond quantities.
- MIN_DELAY, 1000: fixed hold-off in ms. Must be ≥1.
- TIMEOUT, 9999: reaction-count limit in ms.
- Constraints: MIN_DELAY + 4·(2^LFSR_W−1) < 2^TIME_W, and TIMEOUT < 2^TIME_W.

Ports (reset reset, asynchronous, active-high; clock clk):
- clk, in, 1: clock.
- reset, in, 1: async active-high reset.
- start, in, 1: one-cycle pulse that requests a new round.
- press, in, 1: one-cycle pulse for a button press (already debounced and edge-detected).
- lfsr_value, in, LFSR_W: current LFSR state.
- lfsr_en, out, 1: LFSR advance enable.
- lamp, out, 1: "react now" indicator.
- time_ms, out, TIME_W: display value.
- result_valid, out, 1: one-cycle pulse when a round completes. Covers both the press and timeout cases.
- timeout, out, 1: last round timed out.
- false_start, out, 1: last round fouled.
- best_ms, out, TIME_W: best valid result.
- best_valid, out, 1: best_ms holds a real result.

## Operation
States (Moore):
- **IDLE**
  - Outputs: lfsr_en=1, lamp=0.
  - start → ARM.
- **ARM**
  - lamp=0, lfsr_en=0.
  - On entry, delay = MIN_DELAY + (lfsr_value << 2), computed in TIME_W bits from the value sampled in the start cycle.
  - Each tick decrements delay.
  - press → FOUL, with priority over the tick.
  - Tick with delay==1 → GO.
- **GO**
  - lamp=1. count is cleared on entry and increments on each tick.
  - press → DONE, with result = count before any same-cycle increment.
  - Tick with count==TIMEOUT−1 → DONE, with result=TIMEOUT and timeout=1.
- **DONE**
  - lamp=0; time_ms holds the result.
  - start → ARM.
- **FOUL**
  - false_start=1, time_ms=0.
  - start → ARM.

Rules that apply in all states:
- start in ARM or GO is ignored.
- press in IDLE, DONE or FOUL is ignored.
- time_ms shows count in GO, the result in DONE, and 0 elsewhere.
- timeout and false_start are cleared on entry to ARM.
- Best-time update happens on a press-terminated round only: if !best_valid or result<best_ms, then best_ms←result and best_valid←1. Timeouts never update the best time.

## Timing
- The tick prescaler clears on entry to ARM and to GO. Tick asserts on the TICK_DIV-th cycle in the state. GO is entered exactly D·TICK_DIV cycles after ARM entry.
- Press → (DONE, lamp=0, result_valid=1, time_ms=result) in the next cycle. best_ms updates in the same cycle.
- Press → FOUL in the next cycle.
- Reset values:
  - state IDLE, so lfsr_en=1.
  - lamp=0, time_ms=0, result_valid=0, timeout=0, false_start=0, best_ms=0, best_valid=0.
- Reset mid-round aborts immediately. The best-time record is lost.
- count saturates: it never exceeds TIMEOUT.

## Structure
- Package reaction_pkg holds:
  - state enum (IDLE, ARM, GO, DONE, FOUL; 3 bits);
  - default constants (TICK_DIV, MIN_DELAY, TIMEOUT).
- Sub-module tick_gen(clk, reset, clear, tick): the parameterised 1 ms prescaler.
- State register, delay/count register and best-time logic stay in reaction_round_ctrl.

## Test plan
All scenarios use TICK_DIV=4, LFSR_W=4, TIME_W=8, MIN_DELAY=3, TIMEOUT=20.
- **Normal round**
  - Stimulus: start with lfsr_value=2, then press 5 ticks after the lamp rises.
  - Response: lamp rises 44 cycles after ARM entry; result_valid pulses once with time_ms=5; best_ms=5 and best_valid=1.
- **False start**
  - Stimulus: press during ARM.
  - Response: FOUL next cycle, false_start=1, lamp never asserted, no result_valid. A following start clears false_start and re-arms.
- **Timeout**
  - Stimulus: no press in GO.
  - Response: after 20 ticks, result_valid pulses with time_ms=20 and timeout=1; best_ms unchanged.
- **Best tracking**
  - Stimulus: rounds of 5, then 7, then 3.
  - Response: best_ms reads 5, 5, 3.
- **Coincident press and tick**
  - Stimulus: press in GO on the tick cycle with count=6.
  - Response: result 6. Same check in ARM: FOUL, not GO.
- **Reset mid-GO**
  - Stimulus: assert reset with best_valid=1.
  - Response: same cycle, lamp=0, state IDLE, lfsr_en=1, best_valid=0. Also: start during GO has no effect.
